lookup_mat: RTL and testbench

- Parametrised match-action lookup stage; successor to the fixed 1-bit-key, 2-entry lookup stage.
- Sits between parser and output-queue selection. Extracts a KEY_WIDTH-bit key from in_data and indexes a runtime-programmable table of {valid, next, action}.
- Writes the result into out_ctl and passes in_data through. Fixed 2-cycle pipeline, with hit/miss statistics.

---
 rtl/lookup_mat.sv | 190 +++++++++++++++++++
 tb/tb_lookup_mat.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lookup_mat.sv
// Match-action lookup stage: extracts a key from the packet word, looks it up in a
// runtime-programmable {valid, next, action} table and folds the result into out_ctl.
module lookup_mat #(
    parameter int DATA_WIDTH = 480,
    parameter int CTRL_WIDTH = 32,
    parameter int KEY_LSB    = 207,
    parameter int KEY_WIDTH  = 4,
    parameter int NEXT_WIDTH = 2,
    parameter int ACT_WIDTH  = 2,
    parameter int DEF_NEXT   = 3,
    parameter int DEF_ACT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  datavalid,
    input  logic [CTRL_WIDTH-1:0] in_ctl,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  cfg_wr,
    input  logic [KEY_WIDTH-1:0]  cfg_addr,
    input  logic                  cfg_valid,
    input  logic [NEXT_WIDTH-1:0] cfg_next,
    input  logic [ACT_WIDTH-1:0]  cfg_act,
    input  logic                  cnt_clr,
    output logic                  out_wr,
    output logic [CTRL_WIDTH-1:0] out_ctl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);

    localparam int          DEPTH   = 2 ** KEY_WIDTH;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    if (KEY_LSB + KEY_WIDTH > DATA_WIDTH) begin : g_key_range_chk
        $error("lookup_mat: key slice exceeds DATA_WIDTH");
    end
    if (CTRL_WIDTH < 32 || NEXT_WIDTH > 8 || ACT_WIDTH > 6) begin : g_field_chk
        $error("lookup_mat: control field widths out of range");
    end

    logic                  s1_valid_q, s1_valid_d;
    logic [KEY_WIDTH-1:0]  s1_key_q, s1_key_d;
    logic [CTRL_WIDTH-1:0] s1_ctl_q, s1_ctl_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

    logic [DEPTH-1:0]      tbl_valid_q, tbl_valid_d;
    logic [NEXT_WIDTH-1:0] tbl_next_q [DEPTH];
    logic [NEXT_WIDTH-1:0] tbl_next_d [DEPTH];
    logic [ACT_WIDTH-1:0]  tbl_act_q  [DEPTH];
    logic [ACT_WIDTH-1:0]  tbl_act_d  [DEPTH];

    logic                  out_wr_q, out_wr_d;
    logic [CTRL_WIDTH-1:0] out_ctl_q, out_ctl_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [31:0]           hit_cnt_q, hit_cnt_d;
    logic [31:0]           miss_cnt_q, miss_cnt_d;

    logic                  rd_valid_s;
    logic [NEXT_WIDTH-1:0] rd_next_s, res_next_s;
    logic [ACT_WIDTH-1:0]  rd_act_s, res_act_s;
    logic [CTRL_WIDTH-1:0] res_ctl_s;

    // Stage 1 capture of key, control and data.
    always_comb begin
        s1_valid_d = datavalid;
        s1_key_d   = s1_key_q;
        s1_ctl_d   = s1_ctl_q;
        s1_data_d  = s1_data_q;
        if (datavalid) begin
            s1_key_d  = in_data[KEY_LSB +: KEY_WIDTH];
            s1_ctl_d  = in_ctl;
            s1_data_d = in_data;
        end else begin
            s1_key_d  = s1_key_q;
        end
    end

    // Table update from the configuration port.
    always_comb begin
        tbl_valid_d = tbl_valid_q;
        tbl_next_d  = tbl_next_q;
        tbl_act_d   = tbl_act_q;
        if (cfg_wr) begin
            tbl_valid_d[cfg_addr] = cfg_valid;
            tbl_next_d[cfg_addr]  = cfg_next;
            tbl_act_d[cfg_addr]   = cfg_act;
        end else begin
            tbl_valid_d = tbl_valid_q;
        end
    end

    // Table read with same-cycle write bypass, then miss defaulting and result packing.
    always_comb begin
        rd_valid_s = tbl_valid_q[s1_key_q];
        rd_next_s  = tbl_next_q[s1_key_q];
        rd_act_s   = tbl_act_q[s1_key_q];
        if (cfg_wr && (cfg_addr == s1_key_q)) begin
            rd_valid_s = cfg_valid;
            rd_next_s  = cfg_next;
            rd_act_s   = cfg_act;
        end else begin
            rd_valid_s = tbl_valid_q[s1_key_q];
        end
        if (rd_valid_s) begin
            res_next_s = rd_next_s;
            res_act_s  = rd_act_s;
        end else begin
            res_next_s = NEXT_WIDTH'(DEF_NEXT);
            res_act_s  = ACT_WIDTH'(DEF_ACT);
        end
        res_ctl_s                  = s1_ctl_q;
        res_ctl_s[7:0]             = 8'h00;
        res_ctl_s[NEXT_WIDTH-1:0]  = res_next_s;
        res_ctl_s[23:16]           = 8'h00;
        res_ctl_s[16 +: ACT_WIDTH] = res_act_s;
        res_ctl_s[23]              = rd_valid_s;
    end

    // Stage 2 output registers; data/control hold while idle.
    always_comb begin
        out_wr_d   = s1_valid_q;
        out_ctl_d  = out_ctl_q;
        out_data_d = out_data_q;
        if (s1_valid_q) begin
            out_ctl_d  = res_ctl_s;
            out_data_d = s1_data_q;
        end else begin
            out_ctl_d  = out_ctl_q;
        end
    end

    // Statistics: clear first, then count the completing lookup, saturating at max.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (cnt_clr) begin
            hit_cnt_d  = 32'h0000_0000;
            miss_cnt_d = 32'h0000_0000;
        end else begin
            hit_cnt_d  = hit_cnt_q;
        end
        if (s1_valid_q && rd_valid_s && (hit_cnt_d != CNT_MAX)) begin
            hit_cnt_d = hit_cnt_d + 32'd1;
        end else if (s1_valid_q && !rd_valid_s && (miss_cnt_d != CNT_MAX)) begin
            miss_cnt_d = miss_cnt_d + 32'd1;
        end else begin
            hit_cnt_d = hit_cnt_d;
        end
    end

    // Resettable pipeline, table-valid and counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_key_q    <= {KEY_WIDTH{1'b0}};
            s1_ctl_q    <= {CTRL_WIDTH{1'b0}};
            s1_data_q   <= {DATA_WIDTH{1'b0}};
            tbl_valid_q <= {DEPTH{1'b0}};
            out_wr_q    <= 1'b0;
            out_ctl_q   <= {CTRL_WIDTH{1'b0}};
            out_data_q  <= {DATA_WIDTH{1'b0}};
            hit_cnt_q   <= 32'h0000_0000;
            miss_cnt_q  <= 32'h0000_0000;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_key_q    <= s1_key_d;
            s1_ctl_q    <= s1_ctl_d;
            s1_data_q   <= s1_data_d;
            tbl_valid_q <= tbl_valid_d;
            out_wr_q    <= out_wr_d;
            out_ctl_q   <= out_ctl_d;
            out_data_q  <= out_data_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Entry payload storage; meaningless until the entry is marked valid, so no reset.
    always_ff @(posedge clk) begin
        tbl_next_q <= tbl_next_d;
        tbl_act_q  <= tbl_act_d;
    end

    assign out_wr   = out_wr_q;
    assign out_ctl  = out_ctl_q;
    assign out_data = out_data_q;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_lookup_mat.sv
// Directed and randomized bench for lookup_mat against a transaction-level table model.
module tb_lookup_mat;
    localparam int DW = 480;
    localparam int KL = 207;
    localparam int KW = 4;
    localparam int DEF_NEXT = 3;
    localparam int DEF_ACT  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          datavalid = 1'b0;
    logic [31:0]   in_ctl = 32'h0;
    logic [DW-1:0] in_data = '0;
    logic          cfg_wr = 1'b0;
    logic [3:0]    cfg_addr = 4'h0;
    logic          cfg_valid = 1'b0;
    logic [1:0]    cfg_next = 2'h0;
    logic [1:0]    cfg_act = 2'h0;
    logic          cnt_clr = 1'b0;
    logic          out_wr;
    logic [31:0]   out_ctl;
    logic [DW-1:0] out_data;
    logic [31:0]   hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    lookup_mat dut (
        .clk(clk), .rst(rst), .datavalid(datavalid), .in_ctl(in_ctl), .in_data(in_data),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid), .cfg_next(cfg_next),
        .cfg_act(cfg_act), .cnt_clr(cnt_clr), .out_wr(out_wr), .out_ctl(out_ctl),
        .out_data(out_data), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: table contents, counters, the word waiting for lookup, expected outputs.
    bit            m_v [16];
    int            m_n [16];
    int            m_a [16];
    logic [31:0]   m_hit, m_miss;
    bit            p_valid;
    int            p_key;
    logic [31:0]   p_ctl;
    logic [DW-1:0] p_data;
    logic          e_wr;
    logic [31:0]   e_ctl;
    logic [DW-1:0] e_data;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    function automatic logic [31:0] exp_ctl(input logic [31:0] c, input bit hit, input int n, input int a);
        return (c & 32'hFF00_FF00) | (hit ? 32'h0080_0000 : 32'h0000_0000) | (32'(a) << 16) | 32'(n);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
        m_hit = 32'h0; m_miss = 32'h0;
        p_valid = 1'b0;
        e_wr = 1'b0; e_ctl = 32'h0; e_data = '0;
    endtask

    task automatic check_all();
        chk("out_wr", DW'(out_wr), DW'(e_wr));
        chk("out_ctl", DW'(out_ctl), DW'(e_ctl));
        chk("out_data", out_data, e_data);
        chk("hit_cnt", DW'(hit_cnt), DW'(m_hit));
        chk("miss_cnt", DW'(miss_cnt), DW'(m_miss));
    endtask

    // Advance one clock with the currently driven inputs and compare against the model.
    task automatic tick();
        bit v;
        int k, n, a;
        v = 1'b0;
        if (p_valid) begin
            k = p_key; v = m_v[k]; n = m_n[k]; a = m_a[k];
            if (cfg_wr && int'(cfg_addr) == k) begin
                v = cfg_valid; n = int'(cfg_next); a = int'(cfg_act);
            end
            if (!v) begin n = DEF_NEXT; a = DEF_ACT; end
            e_wr = 1'b1; e_ctl = exp_ctl(p_ctl, v, n, a); e_data = p_data;
        end else begin
            e_wr = 1'b0;
        end
        if (cnt_clr) begin m_hit = 32'h0; m_miss = 32'h0; end
        if (p_valid) begin
            if (v) m_hit = sat_inc(m_hit);
            else   m_miss = sat_inc(m_miss);
        end
        if (cfg_wr) begin
            m_v[cfg_addr] = cfg_valid; m_n[cfg_addr] = int'(cfg_next); m_a[cfg_addr] = int'(cfg_act);
        end
        p_valid = datavalid;
        p_key   = int'(in_data[KL +: KW]);
        p_ctl   = in_ctl;
        p_data  = in_data;
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic set_word(input int key, input logic [31:0] ctl);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        d[KL +: KW] = KW'(key);
        datavalid = 1'b1; in_ctl = ctl; in_data = d;
    endtask

    task automatic idle();
        datavalid = 1'b0; cfg_wr = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic cfg(input int addr, input bit v, input int n, input int a);
        cfg_wr = 1'b1; cfg_addr = 4'(addr); cfg_valid = v; cfg_next = 2'(n); cfg_act = 2'(a);
        tick();
        cfg_wr = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk); rst = 1'b1;

        // Post-reset miss on key 5.
        set_word(5, $urandom); tick(); idle(); tick();
        chk("miss_fields", DW'(out_ctl & 32'h00FF_00FF), DW'(32'h0002_0003));
        chk("miss_cnt_1", DW'(miss_cnt), DW'(32'd1));

        // Programmed hit.
        cfg(5, 1'b1, 1, 3);
        set_word(5, 32'hAB00_CD00); tick(); idle(); tick();
        chk("hit_ctl", DW'(out_ctl), DW'(32'hAB83_CD01));
        chk("hit_cnt_1", DW'(hit_cnt), DW'(32'd1));

        // Streaming keys 0..15 with entries 0..7 valid.
        for (int i = 0; i < 16; i++) cfg(i, i < 8, $urandom_range(0, 3), $urandom_range(0, 3));
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int i = 0; i < 16; i++) begin set_word(i, $urandom); tick(); end
        idle(); tick(); tick();
        chk("stream_hits", DW'(hit_cnt), DW'(32'd8));
        chk("stream_misses", DW'(miss_cnt), DW'(32'd8));

        // Write to entry 9 in the cycle its lookup happens.
        set_word(9, $urandom); tick(); idle();
        cfg_wr = 1'b1; cfg_addr = 4'd9; cfg_valid = 1'b1; cfg_next = 2'd2; cfg_act = 2'd1;
        tick(); cfg_wr = 1'b0;
        chk("bypass_fields", DW'(out_ctl & 32'h00FF_00FF), DW'(32'h0081_0002));

        // Randomized traffic, config writes (often aimed at the key being looked up) and clears.
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 3) != 0) set_word($urandom_range(0, 15), $urandom);
            else datavalid = 1'b0;
            cfg_wr    = ($urandom_range(0, 3) == 0);
            cfg_addr  = ($urandom_range(0, 1) == 0) ? 4'(p_key) : 4'($urandom_range(0, 15));
            cfg_valid = $urandom_range(0, 1) != 0;
            cfg_next  = 2'($urandom_range(0, 3));
            cfg_act   = 2'($urandom_range(0, 3));
            cnt_clr   = ($urandom_range(0, 19) == 0);
            tick();
        end
        idle(); tick(); tick();

        // Counter saturation and clear-then-count.
        cfg(5, 1'b1, 2, 2); tick();
        force dut.hit_cnt_d = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        release dut.hit_cnt_d;
        m_hit = 32'hFFFF_FFFE;
        chk("hit_preload", DW'(hit_cnt), DW'(32'hFFFF_FFFE));
        set_word(5, $urandom); tick(); set_word(5, $urandom); tick(); idle(); tick(); tick();
        chk("hit_saturated", DW'(hit_cnt), DW'(32'hFFFF_FFFF));
        set_word(5, $urandom); tick(); idle(); cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("clr_then_count", DW'(hit_cnt), DW'(32'd1));

        // Reset while words are in flight.
        set_word(5, $urandom); @(posedge clk); #1;
        set_word(6, $urandom); #2; rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check_all();
        @(negedge clk); idle(); rst = 1'b1;
        tick(); tick();
        set_word(5, $urandom); tick(); idle(); tick();
        chk("post_rst_hit_flag", DW'(out_ctl[23]), DW'(1'b0));
        chk("post_rst_miss", DW'(miss_cnt), DW'(32'd1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end
endmodule
